sram_read_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 32 +++
 rtl/sram_read_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the image-SRAM read arbiter: default sizes, FSM
// encoding and the fixed requester slot assignment of the decoder sub-engines.
package sram_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 6;
    localparam int ADDR_W_DEFAULT  = 12;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int PRE_SCAN_ID = 0;
    localparam int NUM_ID      = 1;
    localparam int SCAN_ID     = 2;
    localparam int LOC_ID      = 3;
    localparam int ROTATE_ID   = 4;
    localparam int DEMASK_ID   = 5;

endpackage

// File: rtl/arb_pick.sv
// Combinational one-hot picker: first requester at or after start_i, wrapping
// modulo NUM_REQ, found by rotate / isolate-lowest-one / rotate back.
module arb_pick #(
    parameter int NUM_REQ = 6,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] back_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [NUM_REQ-1:0]   first_s;

    // rotate so start_i sits at bit 0, keep the lowest one, rotate back
    always_comb begin
        dbl_s   = {req_i, req_i} >> start_i;
        rot_s   = dbl_s[NUM_REQ-1:0];
        first_s = rot_s & (~rot_s + ONE);
        back_s  = {first_s, first_s} << start_i;
        gnt_o   = back_s[2*NUM_REQ-1:NUM_REQ];
        idx_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_o = idx_o | ({IDX_W{gnt_o[k]}} & IDX_W'(k));
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Single-port image SRAM read arbiter with lockable bursts and a 2-cycle
// tag pipeline. Define SRAM_ARB_RR_EN for round-robin, else fixed priority.
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      srst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         sram_raddr,
    input  logic                      sram_rdata,
    output logic                      rdata,
    output logic [NUM_REQ-1:0]        rdata_vld,
    output logic                      locked
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               v1_q;
    logic [IDX_W-1:0]   id1_q;
    logic [NUM_REQ-1:0] vld_q;

    logic [NUM_REQ-1:0] cand_s;
    logic [NUM_REQ-1:0] pick_gnt_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W-1:0]   start_s;
    logic               any_s;
    logic               win_lock_s;
    logic [ADDR_W-1:0]  win_addr_s;

`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // search starts one past the last ARB-state winner; locked beats never move it
    always_comb begin
        if (ptr_q == IDX_W'(NUM_REQ - 1)) begin
            start_s = '0;
        end else begin
            start_s = ptr_q + IDX_W'(1);
        end
        if (state_q == ARB && any_s) begin
            ptr_d = pick_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // round-robin pointer register
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start_s = '0;
`endif

    // while locked only the owner may compete
    always_comb begin
        if (state_q == LOCKED) begin
            cand_s = req & owner_q;
        end else begin
            cand_s = req;
        end
    end

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (cand_s),
        .start_i (start_s),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s)
    );

    assign any_s      = |pick_gnt_s;
    assign win_lock_s = |(lock & pick_gnt_s);
    assign gnt        = pick_gnt_s;

    // one-hot AND-OR mux of the winner's address
    always_comb begin
        win_addr_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_addr_s = win_addr_s | ({ADDR_W{pick_gnt_s[k]}} & req_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    // lock FSM next state and address hold
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        raddr_d = raddr_q;
        case (state_q)
            ARB: begin
                if (any_s && win_lock_s) begin
                    state_d = LOCKED;
                    owner_d = pick_gnt_s;
                end else begin
                    state_d = ARB;
                end
            end
            LOCKED: begin
                if (|(lock & owner_q)) begin
                    state_d = LOCKED;
                end else begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
        if (any_s) begin
            raddr_d = win_addr_s;
        end else begin
            raddr_d = raddr_q;
        end
    end

    // FSM, SRAM address and tag pipeline registers
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ARB;
            owner_q <= '0;
            raddr_q <= '0;
            v1_q    <= 1'b0;
            id1_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            raddr_q <= raddr_d;
            v1_q    <= any_s;
            id1_q   <= pick_idx_s;
            vld_q   <= v1_q ? (ONE_HOT0 << id1_q) : '0;
        end
    end

    assign sram_raddr = raddr_q;
    assign rdata      = sram_rdata;
    assign rdata_vld  = vld_q;
    assign locked     = (state_q == LOCKED);

endmodule
